// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts at most SHIFT_PER_CYC positions per cycle.
// Optional macro SHIFT_BACK2BACK_EN lets a new op be accepted during the output handshake.
module shift_seq_ctrl #(
    parameter int XLEN          = 32,
    parameter int SHIFT_PER_CYC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [4:0]      in_shamt,
    input  logic [1:0]      in_op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [5:0] SPC     = 6'(SHIFT_PER_CYC);

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [1:0]      op_q, op_d;
    logic            sign_q, sign_d;
    logic [5:0]      rem_q, rem_d;
    logic [5:0]      step;
    logic            accept;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        op_d     = op_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        in_ready = 1'b0;
        step     = (rem_q < SPC) ? rem_q : SPC;

        case (state_q)
            S_IDLE: in_ready = ~flush;
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  res_d = res_q << step;
                    OP_SRL:  res_d = res_q >> step;
                    // sign bit prepended so the arithmetic shift fills from the latched sign
                    OP_SRA:  res_d = XLEN'($signed({sign_q, res_q}) >>> step);
                    default: res_d = res_q;
                endcase
                rem_d = rem_q - step;
                if (rem_q == step) state_d = S_DONE;
            end
            S_DONE: begin
`ifdef SHIFT_BACK2BACK_EN
                in_ready = out_ready & ~flush;
`endif
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        accept = in_valid & in_ready;
        if (accept) begin
            res_d   = in_data;
            op_d    = in_op;
            sign_d  = in_data[XLEN-1];
            rem_d   = {1'b0, in_shamt};
            state_d = (in_shamt == 5'd0 || in_op == OP_PASS) ? S_DONE : S_SHIFT;
        end

        if (flush) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; res is reset too because
    // out_data must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign out_data  = res_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (SHIFT_PER_CYC 8, plus 1 and 32 latency cases).
// Back-to-back expectations follow the SHIFT_BACK2BACK_EN macro.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;

    logic        iv_x, or_x;
    logic        ir1, ov1, by1, ir32, ov32, by32;
    logic [31:0] od1, od32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.XLEN(32), .SHIFT_PER_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    shift_seq_ctrl #(.XLEN(32), .SHIFT_PER_CYC(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir1),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(1'b0),
        .out_valid(ov1), .out_ready(or_x), .out_data(od1), .busy(by1)
    );

    shift_seq_ctrl #(.XLEN(32), .SHIFT_PER_CYC(32)) dut_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir32),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .flush(1'b0),
        .out_valid(ov32), .out_ready(or_x), .out_data(od32), .busy(by32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the SPC=8 instance, measure latency, check result, then drain it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [31:0] exp, input int exp_lat);
        int n;
        in_op    = op;
        in_data  = data;
        in_shamt = shamt;
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 32'h5A5A_1234;
        in_shamt = 5'd3;
        in_op    = 2'b01;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int          n, lat1, lat32, b2b_exp;
        logic [31:0] held, res_a;
        logic        seen_valid, got_a;

        rst_n = 1'b0;  in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '0;  in_shamt = '0;   in_op = 2'b00;
        iv_x = 1'b0;   or_x = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5);
        run_op("sra4", 2'b11, 32'h8000_0000, 5'd4, 32'hF800_0000, 2);
        run_op("srl4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 2);
        run_op("shamt0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
        run_op("pass17", 2'b10, 32'hDEAD_BEEF, 5'd17, 32'hDEAD_BEEF, 1);
        run_op("sra_pos9", 2'b11, 32'h7654_3210, 5'd9, 32'h003B_2A19, 3);
        run_op("sra_neg17", 2'b11, 32'hC000_1234, 5'd17, 32'hFFFF_E000, 4);

        // Hold the result for three cycles with out_ready low.
        in_op = 2'b00; in_data = 32'h0000_00F0; in_shamt = 5'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        held = out_data;
        check("hold_first", held, 32'h0000_F000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, 32'h0000_F000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush during the second SHIFT cycle.
        in_op = 2'b00; in_data = 32'h0000_0001; in_shamt = 5'd31; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        seen_valid = out_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
        end
        check("flush_no_valid", {31'd0, seen_valid}, 32'd0);

        // Reset asserted mid-SHIFT.
        in_op = 2'b01; in_data = 32'hFFFF_FFFF; in_shamt = 5'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_data", out_data, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back SLL ops with out_ready held high.
`ifdef SHIFT_BACK2BACK_EN
        b2b_exp = 2;
`else
        b2b_exp = 3;
`endif
        in_op = 2'b00; in_data = 32'h0000_0001; in_shamt = 5'd4; in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = 32'h0000_0003; in_shamt = 5'd8;
        #1;
        n = 1;
        got_a = 1'b0;
        res_a = '0;
        while (!in_ready && n < 100) begin
            if (out_valid) begin
                got_a = 1'b1;
                res_a = out_data;
            end
            tick();
            n++;
        end
        if (out_valid) begin
            got_a = 1'b1;
            res_a = out_data;
        end
        check("b2b_spacing", 32'(n), 32'(b2b_exp));
        check("b2b_first_seen", {31'd0, got_a}, 32'd1);
        check("b2b_first_data", res_a, 32'h0000_0010);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("b2b_second_lat", 32'(n), 32'd2);
        check("b2b_second_data", out_data, 32'h0000_0300);
        tick();
        out_ready = 1'b0;
        check("b2b_drained", {31'd0, out_valid}, 32'd0);

        // SHIFT_PER_CYC = 1 and 32 latency for SLL shamt 31.
        in_op = 2'b00; in_data = 32'h0000_0001; in_shamt = 5'd31; iv_x = 1'b1;
        #1;
        check("spc_in_ready", {30'd0, ir1, ir32}, 32'd3);
        tick();
        iv_x = 1'b0;
        lat1 = 0;
        lat32 = 0;
        n = 1;
        while ((lat1 == 0 || lat32 == 0) && n < 100) begin
            if (ov1 && lat1 == 0) lat1 = n;
            if (ov32 && lat32 == 0) lat32 = n;
            if (lat1 == 0 || lat32 == 0) begin
                tick();
                n++;
            end
        end
        check("spc1_lat", 32'(lat1), 32'd32);
        check("spc32_lat", 32'(lat32), 32'd2);
        check("spc1_data", od1, 32'h8000_0000);
        check("spc32_data", od32, 32'h8000_0000);
        or_x = 1'b1;
        tick();
        or_x = 1'b0;
        check("spc_drained", {30'd0, ov1, ov32}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
